// File: rtl/cpu_defs_pkg.sv
// Shared fetch-stage definitions: FSM encoding, instruction width and the
// FIFO entry layout used between the fetch FSM and its buffer.
package cpu_defs;

  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction buffer holding {pc, instr} pairs; flush empties it
// and takes priority over a same-cycle push or pop.
module fetch_fifo
  import cpu_defs::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output logic [AW:0]  count,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues single outstanding word
// reads to instruction memory and buffers returned words for decode.
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0]  RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned  DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_din;
  logic          accept;
  logic          push;
  logic          pop;
  logic          credit_idle;
  logic          credit_push;

  assign accept      = (state == ST_REQ) && imem_ack;
  assign push        = (state == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign pop         = if_valid && if_ready && !redirect_valid;
  // Only one request is ever outstanding, so credit reduces to FIFO occupancy.
  assign credit_idle = fifo_count < CW'(DEPTH);
  assign credit_push = (fifo_count + 1'b1) < CW'(DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else if (accept) begin
      pend_pc  <= fetch_pc;
      fetch_pc <= fetch_pc + 32'(WORD_BYTES);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!redirect_valid && credit_idle) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid)  state_nxt = imem_ack ? ST_DISCARD : ST_IDLE;
        else if (imem_ack)   state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid)         state_nxt = (!redirect_valid && credit_push) ? ST_REQ : ST_IDLE;
        else if (redirect_valid) state_nxt = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (imem_rvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == ST_REQ);
    imem_addr = fetch_pc;
    if_valid  = !fifo_empty;
    if_instr  = fifo_head.instr;
    if_pc     = fifo_head.pc;
  end

  assign fifo_din = '{pc: pend_pc, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .flush (redirect_valid),
    .count (fifo_count),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule
